branch_predictor_gshare_assoc: RTL and testbench

Next-generation fetch-stage branch predictor: a gshare direction predictor plus a 2-way set-associative BTB with per-set LRU replacement, and an optional return-address stack (RAS). It sits between IF (zero-latency lookup on `fetch_pc`) and EX (resolved-branch training). All widths and depths are parametrised.

---
 rtl/branch_predictor_gshare_assoc_pkg.sv | 36 +++
 rtl/branch_predictor_gshare_assoc_if.sv | 33 +++
 rtl/branch_predictor_gshare_assoc_ras.sv | 60 ++++++
 rtl/branch_predictor_gshare_assoc.sv | 176 +++++++++++++++++
 tb/tb_branch_predictor_gshare_assoc.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_gshare_assoc_pkg.sv
// -----------------------------------------------------------------------------
// bpu_pkg
// Shared types for the gshare + 2-way BTB branch predictor:
//   br_type_e    - EX-stage branch classification (NONE/JAL/BTYPE/RET)
//   btb_kind_e   - what a BTB entry was trained as
//   CNT_*        - 2-bit direction counter encodings
//   sat_cnt_next - saturating +/-1 step of a direction counter
// -----------------------------------------------------------------------------
package bpu_pkg;

    typedef enum logic [1:0] {
        BR_NONE  = 2'b00,
        BR_JAL   = 2'b01,
        BR_BTYPE = 2'b10,
        BR_RET   = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        KIND_B   = 2'b00,
        KIND_JAL = 2'b01,
        KIND_RET = 2'b10
    } btb_kind_e;

    localparam logic [1:0] CNT_SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] CNT_WT  = 2'b10;  // weak taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strong taken

    function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'b01;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_assoc_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_gshare_assoc_if
// Fetch-lookup and EX-training signals of the branch predictor.
//   master: pipeline side (drives stall, fetch_pc, ex_*; receives prediction)
//   slave : predictor side
// Signal contract: there is no valid/ready pair. fetch_pc is looked up every
// cycle and fetch_hit/fetch_target answer combinationally in the same cycle.
// An EX record (ex_branch_type != NONE, or ex_call) is consumed on every
// rising edge where stall=0; while stall=1 it is held and nothing is consumed.
// -----------------------------------------------------------------------------
interface branch_predictor_gshare_assoc_if #(
    parameter int PC_WIDTH = 16
);
    logic                stall;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                fetch_hit;
    logic [PC_WIDTH-1:0] fetch_target;
    logic [1:0]          ex_branch_type;
    logic                ex_call;
    logic                ex_taken;
    logic [PC_WIDTH-1:0] ex_pc;
    logic [PC_WIDTH-1:0] ex_target;

    modport master (
        output stall, fetch_pc, ex_branch_type, ex_call, ex_taken, ex_pc, ex_target,
        input  fetch_hit, fetch_target
    );

    modport slave (
        input  stall, fetch_pc, ex_branch_type, ex_call, ex_taken, ex_pc, ex_target,
        output fetch_hit, fetch_target
    );
endinterface

// File: rtl/branch_predictor_gshare_assoc_ras.sv
// -----------------------------------------------------------------------------
// bpu_ras
// Circular return-address stack. Pushing when full overwrites the oldest
// entry; popping when empty does nothing. Push and pop in the same cycle
// replace the top (or act as a plain push when empty).
// Ports:
//   clk, rst (async, active-low)
//   push, pop, push_data - update controls (already gated by stall)
//   top, empty           - current top-of-stack and empty flag
// -----------------------------------------------------------------------------
module bpu_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;   // next free slot; top lives one below
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;

    assign top_ptr = wr_ptr - PTR_ONE;
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            count  <= '0;
        end else if (push && pop && !empty) begin
            mem[top_ptr] <= push_data;
        end else if (push) begin
            // Power-of-two depth: the pointer wraps onto the oldest entry.
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
            if (count != CNT_FULL) begin
                count <= count + CNT_ONE;
            end
        end else if (pop && !empty) begin
            wr_ptr <= top_ptr;
            count  <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/branch_predictor_gshare_assoc.sv
// -----------------------------------------------------------------------------
// branch_predictor_gshare_assoc
// Fetch-stage predictor: gshare direction PHT + 2-way set-associative BTB with
// one LRU bit per set, optional return-address stack.
// Configuration macro: BPU_RAS_EN (defined -> RAS present, RET entries predict
// the RAS top and ex_call pushes; undefined -> RET behaves like JAL).
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bp  - slave modport: stall, fetch_pc -> fetch_hit/fetch_target (combinational),
//         ex_branch_type/ex_call/ex_taken/ex_pc/ex_target training inputs
// -----------------------------------------------------------------------------
module branch_predictor_gshare_assoc
    import bpu_pkg::*;
#(
    parameter int PC_WIDTH    = 16,
    parameter int BTB_SETS    = 8,
    parameter int PHT_ENTRIES = 64,
    parameter int RAS_DEPTH   = 4
) (
    input logic clk,
    input logic rst,
    branch_predictor_gshare_assoc_if.slave bp
);
    localparam int SET_W = $clog2(BTB_SETS);
    localparam int G     = $clog2(PHT_ENTRIES);
    localparam int TAG_W = PC_WIDTH - SET_W - 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [PC_WIDTH-1:0] target;
        btb_kind_e           kind;
    } btb_entry_t;

    btb_entry_t    btb [BTB_SETS][2];
    logic [BTB_SETS-1:0] lru;        // per set: way to evict next
    logic [1:0]    pht [PHT_ENTRIES];
    logic [G-1:0]  ghr;

    logic                ras_valid;
    logic [PC_WIDTH-1:0] ras_top;

    // ---------------- lookup (combinational) ----------------
    logic [SET_W-1:0] f_set;
    logic [TAG_W-1:0] f_tag;
    logic [G-1:0]     f_idx;
    logic             f_match0, f_match1;
    btb_entry_t       f_entry;

    assign f_set = bp.fetch_pc[SET_W+1:2];
    assign f_tag = bp.fetch_pc[PC_WIDTH-1:SET_W+2];
    assign f_idx = bp.fetch_pc[G+1:2] ^ ghr;

    always_comb begin
        f_match0        = btb[f_set][0].valid && (btb[f_set][0].tag == f_tag);
        f_match1        = btb[f_set][1].valid && (btb[f_set][1].tag == f_tag);
        f_entry         = f_match0 ? btb[f_set][0] : btb[f_set][1];
        bp.fetch_hit    = 1'b0;
        bp.fetch_target = '0;
        if (f_match0 || f_match1) begin
            case (f_entry.kind)
                KIND_JAL: begin
                    bp.fetch_hit    = 1'b1;
                    bp.fetch_target = f_entry.target;
                end
                KIND_B: begin
                    if (pht[f_idx][1]) begin
                        bp.fetch_hit    = 1'b1;
                        bp.fetch_target = f_entry.target;
                    end
                end
                KIND_RET: begin
                    bp.fetch_hit    = 1'b1;
                    bp.fetch_target = ras_valid ? ras_top : f_entry.target;
                end
                default: begin
                    bp.fetch_hit    = 1'b0;
                    bp.fetch_target = '0;
                end
            endcase
        end
    end

    // ---------------- training ----------------
    br_type_e         e_type;
    logic [SET_W-1:0] e_set;
    logic [TAG_W-1:0] e_tag;
    logic [G-1:0]     e_idx;
    logic             e_match0, e_match1, e_hit;
    logic             wr_way;
    btb_kind_e        e_kind;
    logic [G:0]       ghr_shift;

    assign e_type    = br_type_e'(bp.ex_branch_type);
    assign e_set     = bp.ex_pc[SET_W+1:2];
    assign e_tag     = bp.ex_pc[PC_WIDTH-1:SET_W+2];
    assign e_idx     = bp.ex_pc[G+1:2] ^ ghr;
    assign ghr_shift = {ghr, bp.ex_taken};

    always_comb begin
        e_match0 = btb[e_set][0].valid && (btb[e_set][0].tag == e_tag);
        e_match1 = btb[e_set][1].valid && (btb[e_set][1].tag == e_tag);
        e_hit    = e_match0 || e_match1;
        // Hit: way 0 has priority. Miss: first invalid way, else the LRU victim.
        if (e_hit) begin
            wr_way = !e_match0;
        end else if (!btb[e_set][0].valid) begin
            wr_way = 1'b0;
        end else if (!btb[e_set][1].valid) begin
            wr_way = 1'b1;
        end else begin
            wr_way = lru[e_set];
        end
        case (e_type)
            BR_JAL:  e_kind = KIND_JAL;
            BR_RET:  e_kind = KIND_RET;
            default: e_kind = KIND_B;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < BTB_SETS; s++) begin
                for (int w = 0; w < 2; w++) begin
                    btb[s][w] <= '0;
                end
            end
            for (int p = 0; p < PHT_ENTRIES; p++) begin
                pht[p] <= CNT_WT;
            end
            lru <= '0;
            ghr <= '0;
        end else if (!bp.stall && e_type != BR_NONE) begin
            btb[e_set][wr_way] <= '{valid: 1'b1, tag: e_tag, target: bp.ex_target, kind: e_kind};
            lru[e_set]         <= ~wr_way;
            if (e_type == BR_BTYPE) begin
                pht[e_idx] <= e_hit ? sat_cnt_next(pht[e_idx], bp.ex_taken)
                                    : (bp.ex_taken ? CNT_WT : CNT_WNT);
                ghr        <= ghr_shift[G-1:0];
            end
        end
    end

    // ---------------- return-address stack ----------------
`ifdef BPU_RAS_EN
    logic ras_empty;

    bpu_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_WIDTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (!bp.stall && bp.ex_call),
        .pop       (!bp.stall && (e_type == BR_RET)),
        .push_data (bp.ex_pc + PC_WIDTH'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    assign ras_valid = !ras_empty;
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_call;

    assign unused_call = bp.ex_call;
    assign ras_valid   = 1'b0;
    assign ras_top     = '0;
`endif

    // Low PC bits are always word-aligned and carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.fetch_pc[1:0], bp.ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_gshare_assoc.sv
module tb_branch_predictor_gshare_assoc;
    import bpu_pkg::*;

    localparam int PC_WIDTH    = 16;
    localparam int BTB_SETS    = 8;
    localparam int PHT_ENTRIES = 64;
    localparam int RAS_DEPTH   = 4;
    localparam int SET_W       = $clog2(BTB_SETS);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_gshare_assoc_if #(.PC_WIDTH(PC_WIDTH)) bif ();

    branch_predictor_gshare_assoc #(
        .PC_WIDTH    (PC_WIDTH),
        .BTB_SETS    (BTB_SETS),
        .PHT_ENTRIES (PHT_ENTRIES),
        .RAS_DEPTH   (RAS_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bif)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit                  valid;
        int unsigned         tag;
        logic [PC_WIDTH-1:0] target;
        int                  kind;   // uses branch-type code: 1 JAL, 2 B, 3 RET
    } m_entry_t;

    m_entry_t            m_btb [BTB_SETS][2];
    int                  m_victim [BTB_SETS];
    int                  m_pht [PHT_ENTRIES];
    int unsigned         m_ghr;
    logic [PC_WIDTH-1:0] m_ras [$];

    int total = 0;
    int bad   = 0;
    logic [PC_WIDTH:0] exp_q [$];

    function automatic void model_reset();
        for (int s = 0; s < BTB_SETS; s++) begin
            m_victim[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_btb[s][w].valid  = 1'b0;
                m_btb[s][w].tag    = 0;
                m_btb[s][w].target = '0;
                m_btb[s][w].kind   = 0;
            end
        end
        for (int p = 0; p < PHT_ENTRIES; p++) m_pht[p] = 2;
        m_ghr = 0;
        m_ras.delete();
    endfunction

    function automatic logic [PC_WIDTH:0] model_predict(input int unsigned pc);
        int unsigned set_i, tag_v, idx;
        set_i = (pc >> 2) % BTB_SETS;
        tag_v = pc >> (2 + SET_W);
        idx   = ((pc >> 2) % PHT_ENTRIES) ^ m_ghr;
        for (int w = 0; w < 2; w++) begin
            if (m_btb[set_i][w].valid && m_btb[set_i][w].tag == tag_v) begin
                if (m_btb[set_i][w].kind == 2) begin
                    if (m_pht[idx] >= 2) return {1'b1, m_btb[set_i][w].target};
                    return '0;
                end
                if (m_btb[set_i][w].kind == 3) begin
`ifdef BPU_RAS_EN
                    if (m_ras.size() > 0) return {1'b1, m_ras[m_ras.size() - 1]};
`endif
                end
                return {1'b1, m_btb[set_i][w].target};
            end
        end
        return '0;
    endfunction

    function automatic void model_update(input int t, input bit c, input bit tk,
                                         input int unsigned pc, input logic [PC_WIDTH-1:0] tgt);
        int unsigned set_i, tag_v, idx;
        int way;
        set_i = (pc >> 2) % BTB_SETS;
        tag_v = pc >> (2 + SET_W);
        idx   = ((pc >> 2) % PHT_ENTRIES) ^ m_ghr;
        if (t != 0) begin
            way = -1;
            for (int w = 1; w >= 0; w--) begin
                if (m_btb[set_i][w].valid && m_btb[set_i][w].tag == tag_v) way = w;
            end
            if (way >= 0) begin
                if (t == 2) m_pht[idx] = tk ? ((m_pht[idx] == 3) ? 3 : m_pht[idx] + 1)
                                            : ((m_pht[idx] == 0) ? 0 : m_pht[idx] - 1);
            end else begin
                if (!m_btb[set_i][0].valid)      way = 0;
                else if (!m_btb[set_i][1].valid) way = 1;
                else                             way = m_victim[set_i];
                if (t == 2) m_pht[idx] = tk ? 2 : 1;
            end
            m_btb[set_i][way].valid  = 1'b1;
            m_btb[set_i][way].tag    = tag_v;
            m_btb[set_i][way].target = tgt;
            m_btb[set_i][way].kind   = t;
            m_victim[set_i]          = 1 - way;
            if (t == 2) m_ghr = ((m_ghr << 1) | int'(tk)) % PHT_ENTRIES;
        end
`ifdef BPU_RAS_EN
        begin
            logic [PC_WIDTH-1:0] ret_addr;
            ret_addr = PC_WIDTH'(pc + 4);
            if (c && t == 3) begin
                if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = ret_addr;
                else m_ras.push_back(ret_addr);
            end else if (c) begin
                m_ras.push_back(ret_addr);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end else if (t == 3 && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
`else
        if (c) begin end
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic train(input logic st, input logic [1:0] t, input logic c, input logic tk,
                         input logic [PC_WIDTH-1:0] pc, input logic [PC_WIDTH-1:0] tgt);
        @(negedge clk);
        bif.stall          = st;
        bif.ex_branch_type = t;
        bif.ex_call        = c;
        bif.ex_taken       = tk;
        bif.ex_pc          = pc;
        bif.ex_target      = tgt;
        @(posedge clk);
        #1;
        bif.stall          = 1'b0;
        bif.ex_branch_type = 2'b00;
        bif.ex_call        = 1'b0;
        if (!st) model_update(int'(t), c, tk, pc, tgt);
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare(input string name);
        logic [PC_WIDTH:0] obs, exp_v;
        #1;
        obs   = {bif.fetch_hit, bif.fetch_target};
        exp_v = exp_q.pop_front();
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed hit=%0b target=%h, expected hit=%0b target=%h",
                   name, obs[PC_WIDTH], obs[PC_WIDTH-1:0], exp_v[PC_WIDTH], exp_v[PC_WIDTH-1:0]);
        end
    endtask

    task automatic look_const(input logic [PC_WIDTH-1:0] pc, input logic hit,
                              input logic [PC_WIDTH-1:0] tgt, input string name);
        bif.fetch_pc = pc;
        exp_q.push_back({hit, tgt});
        compare(name);
    endtask

    task automatic look_model(input logic [PC_WIDTH-1:0] pc, input string name);
        bif.fetch_pc = pc;
        exp_q.push_back(model_predict(pc));
        compare(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bif.stall          = 1'b0;
        bif.fetch_pc       = '0;
        bif.ex_branch_type = 2'b00;
        bif.ex_call        = 1'b0;
        bif.ex_taken       = 1'b0;
        bif.ex_pc          = '0;
        bif.ex_target      = '0;
        model_reset();

        repeat (2) @(posedge clk);
        look_const(16'h0040, 1'b0, 16'h0000, "reset_0040");
        look_const(16'hfffc, 1'b0, 16'h0000, "reset_fffc");
        @(negedge clk);
        rst = 1'b1;

        // B-type taken allocates with weak-taken; lookup next cycle hits.
        train(1'b0, 2'b10, 1'b0, 1'b1, 16'h0040, 16'h0080);
        look_const(16'h0040, 1'b1, 16'h0080, "btype_taken");

        // Six not-taken outcomes flush history to zero (touching other counters).
        repeat (6) train(1'b0, 2'b10, 1'b0, 1'b0, 16'h0040, 16'h0080);
        look_const(16'h0040, 1'b1, 16'h0080, "ghr_flushed");
        train(1'b0, 2'b10, 1'b0, 1'b0, 16'h0040, 16'h0080);
        look_const(16'h0040, 1'b0, 16'h0000, "btype_nt_weak");
        train(1'b0, 2'b10, 1'b0, 1'b0, 16'h0040, 16'h0080);
        look_const(16'h0040, 1'b0, 16'h0000, "btype_nt_strong");

        // Same-cycle lookup and update of the same counter sees old state.
        @(negedge clk);
        bif.ex_branch_type = 2'b10;
        bif.ex_taken       = 1'b1;
        bif.ex_pc          = 16'h0040;
        bif.ex_target      = 16'h0080;
        look_const(16'h0040, 1'b0, 16'h0000, "same_cycle_old");
        @(posedge clk);
        #1;
        bif.ex_branch_type = 2'b00;
        model_update(2, 1'b0, 1'b1, 16'h0040, 16'h0080);

        // Stall freezes BTB/PHT/GHR.
        train(1'b1, 2'b10, 1'b0, 1'b1, 16'h0088, 16'h0300);
        look_const(16'h0088, 1'b0, 16'h0000, "stall_no_alloc");
        look_model(16'h0040, "stall_ghr_kept");
        train(1'b0, 2'b10, 1'b0, 1'b1, 16'h0088, 16'h0300);
        look_const(16'h0088, 1'b1, 16'h0300, "unstall_alloc");

        // Three JALs into set 4: the third evicts the first.
        train(1'b0, 2'b01, 1'b0, 1'b0, 16'h0010, 16'h1000);
        train(1'b0, 2'b01, 1'b0, 1'b0, 16'h0030, 16'h3000);
        look_const(16'h0010, 1'b1, 16'h1000, "jal_way0");
        train(1'b0, 2'b01, 1'b0, 1'b0, 16'h0050, 16'h5000);
        look_const(16'h0010, 1'b0, 16'h0000, "jal_evicted");
        look_const(16'h0030, 1'b1, 16'h3000, "jal_kept_30");
        look_const(16'h0050, 1'b1, 16'h5000, "jal_kept_50");
        // A hit on 0x0030 refreshes LRU, so the next allocation evicts 0x0050.
        train(1'b0, 2'b01, 1'b0, 1'b0, 16'h0030, 16'h3004);
        train(1'b0, 2'b01, 1'b0, 1'b0, 16'h0010, 16'h1000);
        look_const(16'h0050, 1'b0, 16'h0000, "lru_refresh_evict");
        look_const(16'h0030, 1'b1, 16'h3004, "lru_refresh_keep");

        // Return handling.
        train(1'b0, 2'b11, 1'b0, 1'b0, 16'h0804, 16'h0abc);
        look_const(16'h0804, 1'b1, 16'h0abc, "ret_stored");
        for (int k = 1; k <= 5; k++) train(1'b0, 2'b00, 1'b1, 1'b0, 16'(k * 256), 16'h0000);
`ifdef BPU_RAS_EN
        look_const(16'h0804, 1'b1, 16'h0504, "ras_top1");
        train(1'b0, 2'b11, 1'b0, 1'b0, 16'h0804, 16'h0504);
        look_const(16'h0804, 1'b1, 16'h0404, "ras_top2");
        train(1'b0, 2'b11, 1'b0, 1'b0, 16'h0804, 16'h0404);
        look_const(16'h0804, 1'b1, 16'h0304, "ras_top3");
        train(1'b0, 2'b11, 1'b0, 1'b0, 16'h0804, 16'h0304);
        look_const(16'h0804, 1'b1, 16'h0204, "ras_top4");
        train(1'b0, 2'b11, 1'b0, 1'b0, 16'h0804, 16'h0204);
        look_const(16'h0804, 1'b1, 16'h0204, "ras_empty_fallback");
        train(1'b0, 2'b11, 1'b0, 1'b0, 16'h0804, 16'h0777);
        look_const(16'h0804, 1'b1, 16'h0777, "ras_pop_empty");
        train(1'b0, 2'b00, 1'b1, 1'b0, 16'h0100, 16'h0000);
        train(1'b0, 2'b11, 1'b1, 1'b0, 16'h0600, 16'h0999);
        look_const(16'h0804, 1'b1, 16'h0604, "ras_pop_push");
        train(1'b0, 2'b11, 1'b0, 1'b0, 16'h0804, 16'h0aaa);
        look_const(16'h0804, 1'b1, 16'h0aaa, "ras_depth_kept");
`else
        look_const(16'h0804, 1'b1, 16'h0abc, "ret_no_ras");
        train(1'b0, 2'b11, 1'b1, 1'b0, 16'h0804, 16'h0504);
        look_const(16'h0804, 1'b1, 16'h0504, "ret_retarget");
`endif

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b0;
        model_reset();
        look_const(16'h0030, 1'b0, 16'h0000, "midreset_clear");
        @(negedge clk);
        rst                = 1'b1;
        bif.ex_branch_type = 2'b01;
        bif.ex_pc          = 16'h0030;
        bif.ex_target      = 16'h3333;
        @(posedge clk);
        #1;
        bif.ex_branch_type = 2'b00;
        model_update(1, 1'b0, 1'b0, 16'h0030, 16'h3333);
        look_const(16'h0030, 1'b1, 16'h3333, "first_edge_after_reset");

        // Randomised training against the model.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] t;
            logic c, tk, st;
            logic [PC_WIDTH-1:0] pc, tgt;
            t   = 2'($urandom_range(0, 3));
            c   = ($urandom_range(0, 3) == 0);
            tk  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 7) == 0);
            pc  = 16'($urandom_range(0, 63) << 2);
            tgt = 16'($urandom_range(0, 65535));
            train(st, t, c, tk, pc, tgt);
            look_model(16'($urandom_range(0, 63) << 2), "rand_lookup");
            if (i % 4 == 0) look_model(pc, "rand_trained_pc");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
